hazard_forward_mc: RTL and testbench
====================================

Name: hazard_forward_mc

Overview:
- Parametrised hazard/forwarding unit for the 5-stage pipeline; replaces the single-cycle-memory hazard unit.
- Adds variable-latency memory support through a ready handshake and a wait FSM with a timeout watchdog.
- Adds taken-branch flush control, per-stage stall/bubble outputs, and a saturating stall-cycle performance counter.
- Sits beside the pipeline registers and drives their enable/clear inputs plus the EX/branch operand muxes.

Parameters:
- REG_W, 4, register-specifier width (2^REG_W architectural registers).
- ZERO_REG_HARDWIRED, 1, when 1 register 0 is never a forwarding or stall source.
- TIMEOUT, 64, maximum MEM_WAIT cycles before abort (>=2).
- CNT_W, 16, width of stall performance counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- reg_wr_enX/M/W  in  1 each  register write enable, EX/MEM/WB
- write_regX/M/W  in  REG_W each  destination register, EX/MEM/WB
- mem_to_regX/M  in  1 each  load in EX/MEM
- rr1_reg_D, rr2_reg_D  in  REG_W  decode sources
- rr1_reg_X, rr2_reg_X  in  REG_W  execute sources
- branch_D  in  1  branch in decode reading rr1_reg_D
- branch_taken_D  in  1  branch resolved taken in decode
- mem_req_M  in  1  load/store active in MEM
- mem_ready  in  1  memory completes this cycle
- forwardD  out  2  branch operand select: 00 RF, 01 EX, 10 MEM, 11 WB
- forward_A_selX, forward_B_selX  out  2  ALU operand select: 00 RF, 01 MEM, 10 WB
- stall_F, stall_D, stall_X, stall_M  out  1  hold pipeline register
- bubble_X  out  1  clear ID/EX register (insert NOP)
- bubble_W  out  1  clear MEM/WB register
- flush_D  out  1  clear IF/ID register
- mem_timeout  out  1  sticky watchdog error
- stall_cycles  out  CNT_W  saturating count of cycles with stall_F=1

Behaviour:
- Source match qualifier:
  - A match requires reg_wr_en of the producing stage to be 1.
  - When ZERO_REG_HARDWIRED=1, it also requires the destination register to be nonzero.
- Operand forwarding (combinational):
  - A and B use identical priority: MEM(01) over WB(10) over none(00).
  - forwardD priority: EX(01) over MEM(10) over WB(11) over none(00).
- Load-use hazard (ld_haz), combinational:
  - mem_to_regX with write_regX matching rr1_reg_D or rr2_reg_D, OR
  - branch_D & mem_to_regM with write_regM matching rr1_reg_D.
- FSM states: IDLE, MEM_WAIT.
  - IDLE → MEM_WAIT when mem_req_M & ~mem_ready.
  - MEM_WAIT → IDLE when mem_ready, or when wait count = TIMEOUT-1.
  - On the timeout exit, set mem_timeout; it stays set until rst.
  - wait count clears on every entry to MEM_WAIT.
- mem_stall is combinational: (state==IDLE & mem_req_M & ~mem_ready) | (state==MEM_WAIT & ~mem_ready & ~timeout_exit).
  - This gives zero added latency when memory is ready in the request cycle.
- Priority, with mem_stall highest:
  - mem_stall: stall_F/D/X/M=1, bubble_W=1, bubble_X=0, flush_D=0.
  - else ld_haz: stall_F/D=1, bubble_X=1, flush_D=0. A taken branch is suppressed; it re-resolves next cycle with correct data.
  - else branch_taken_D: flush_D=1.
  - else all stall/bubble/flush outputs 0.
- stall_cycles increments when stall_F=1 and saturates at all-ones.
- Reset values:
  - state=IDLE, wait count=0, mem_timeout=0, stall_cycles=0.
  - All combinational outputs reflect IDLE, so with idle inputs every stall/flush/bubble output is 0.
- Reset asserted mid-MEM_WAIT returns to IDLE on the next edge, regardless of mem_ready.

Decomposition:
- Shared package (pipeline_pkg) holds:
  - the forwarding select encodings: FWD_RF, FWD_MEM, FWD_WB, and BFWD_EX/MEM/WB;
  - the FSM state enum.
- One sub-module, mem_wait_fsm, owns the FSM, wait counter, timeout flag, and mem_stall output.
- Forwarding and ld_haz logic stay inline in hazard_forward_mc.

Test Plan:
- Forward priority: reg_wr_enM=reg_wr_enW=1, write_regM=write_regW=rr1_reg_X=rr2_reg_X=5 → forward_A_selX=forward_B_selX=01. Same case with reg 0 → both 00.
- Load-use: mem_to_regX=1, write_regX=3, rr2_reg_D=3 → one cycle of stall_F=stall_D=bubble_X=1. Next cycle (load moved to MEM, no branch) → all 0; stall_cycles=1.
- Branch after load: branch_D=1, branch_taken_D=1, mem_to_regM=1, write_regM=7=rr1_reg_D → stall_F=1 and flush_D=0. Remove the hazard → flush_D=1.
- Memory wait: mem_req_M=1, mem_ready low for 3 cycles then high → stall_F/D/X/M and bubble_W high for exactly 3 cycles, state returns to IDLE, stall_cycles=3.
- Timeout: TIMEOUT=4, mem_ready held 0 → mem_stall drops after 4 cycles, mem_timeout=1 and stays set; rst → 0.
- Reset mid-wait: rst during MEM_WAIT → next cycle state IDLE, all stalls 0, stall_cycles=0.

Source files
------------

// File: rtl/hazard_forward_mc_pkg.sv
// Shared encodings for the pipeline hazard/forwarding unit: operand-mux selects
// and the memory-wait FSM state type.
package pipeline_pkg;

  // ALU operand select (forward_A_selX / forward_B_selX)
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Branch operand select (forwardD)
  localparam logic [1:0] BFWD_RF  = 2'b00;
  localparam logic [1:0] BFWD_EX  = 2'b01;
  localparam logic [1:0] BFWD_MEM = 2'b10;
  localparam logic [1:0] BFWD_WB  = 2'b11;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } wait_state_e;

endpackage

// File: rtl/hazard_forward_mc_if.sv
// Pipeline-side signal bundle of the hazard unit; the pipeline is the master,
// the hazard unit the slave.
interface hazard_forward_mc_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic             reg_wr_enX, reg_wr_enM, reg_wr_enW;
  logic [REG_W-1:0] write_regX, write_regM, write_regW;
  logic             mem_to_regX, mem_to_regM;
  logic [REG_W-1:0] rr1_reg_D, rr2_reg_D;
  logic [REG_W-1:0] rr1_reg_X, rr2_reg_X;
  logic             branch_D, branch_taken_D;
  logic             mem_req_M, mem_ready;

  logic [1:0]       forwardD;
  logic [1:0]       forward_A_selX, forward_B_selX;
  logic             stall_F, stall_D, stall_X, stall_M;
  logic             bubble_X, bubble_W, flush_D;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output reg_wr_enX, reg_wr_enM, reg_wr_enW,
    output write_regX, write_regM, write_regW,
    output mem_to_regX, mem_to_regM,
    output rr1_reg_D, rr2_reg_D, rr1_reg_X, rr2_reg_X,
    output branch_D, branch_taken_D, mem_req_M, mem_ready,
    input  forwardD, forward_A_selX, forward_B_selX,
    input  stall_F, stall_D, stall_X, stall_M,
    input  bubble_X, bubble_W, flush_D, mem_timeout, stall_cycles
  );

  modport slave (
    input  reg_wr_enX, reg_wr_enM, reg_wr_enW,
    input  write_regX, write_regM, write_regW,
    input  mem_to_regX, mem_to_regM,
    input  rr1_reg_D, rr2_reg_D, rr1_reg_X, rr2_reg_X,
    input  branch_D, branch_taken_D, mem_req_M, mem_ready,
    output forwardD, forward_A_selX, forward_B_selX,
    output stall_F, stall_D, stall_X, stall_M,
    output bubble_X, bubble_W, flush_D, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_forward_mc_mem_wait_fsm.sv
// Variable-latency memory wait tracker: holds the pipeline while MEM waits for
// mem_ready and aborts with a sticky error after TIMEOUT cycles.
module mem_wait_fsm
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  input  logic mem_ready,
  output logic mem_stall,
  output logic mem_timeout
);
  localparam int CNT_BITS = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_BITS-1:0] LAST_WAIT = CNT_BITS'(TIMEOUT - 1);

  wait_state_e         state_q, state_d;
  logic [CNT_BITS-1:0] wait_cnt_q;
  logic                timeout_exit;

  // NOTE: every output of this block gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    timeout_exit = 1'b0;
    mem_stall    = 1'b0;
    if (state_q == IDLE) begin
      if (mem_req && !mem_ready) begin
        state_d   = MEM_WAIT;
        mem_stall = 1'b1;
      end
    end else begin
      timeout_exit = !mem_ready && (wait_cnt_q == LAST_WAIT);
      mem_stall    = !mem_ready && !timeout_exit;
      if (mem_ready || timeout_exit) state_d = IDLE;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      // Held at zero while idle so every MEM_WAIT entry starts a fresh count.
      if (state_q == IDLE) wait_cnt_q <= '0;
      else                 wait_cnt_q <= wait_cnt_q + 1'b1;
      if (timeout_exit) mem_timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/hazard_forward_mc.sv
// Hazard/forwarding unit for the 5-stage pipeline with variable-latency memory,
// taken-branch flush and a saturating stall-cycle counter.
module hazard_forward_mc
  import pipeline_pkg::*;
#(
  parameter int REG_W              = 4,
  parameter int ZERO_REG_HARDWIRED = 1,
  parameter int TIMEOUT            = 64,
  parameter int CNT_W              = 16
) (
  input logic                clk,
  input logic                rst,
  hazard_forward_mc_if.slave hz
);
  logic             ld_haz, mem_stall;
  logic [CNT_W-1:0] stall_cnt_q;

  function automatic logic src_match(input logic en,
                                     input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] src);
    return en && (dst == src) && ((ZERO_REG_HARDWIRED == 0) || (dst != '0));
  endfunction

  always_comb begin
    hz.forward_A_selX = FWD_RF;
    if      (src_match(hz.reg_wr_enM, hz.write_regM, hz.rr1_reg_X)) hz.forward_A_selX = FWD_MEM;
    else if (src_match(hz.reg_wr_enW, hz.write_regW, hz.rr1_reg_X)) hz.forward_A_selX = FWD_WB;

    hz.forward_B_selX = FWD_RF;
    if      (src_match(hz.reg_wr_enM, hz.write_regM, hz.rr2_reg_X)) hz.forward_B_selX = FWD_MEM;
    else if (src_match(hz.reg_wr_enW, hz.write_regW, hz.rr2_reg_X)) hz.forward_B_selX = FWD_WB;

    hz.forwardD = BFWD_RF;
    if      (src_match(hz.reg_wr_enX, hz.write_regX, hz.rr1_reg_D)) hz.forwardD = BFWD_EX;
    else if (src_match(hz.reg_wr_enM, hz.write_regM, hz.rr1_reg_D)) hz.forwardD = BFWD_MEM;
    else if (src_match(hz.reg_wr_enW, hz.write_regW, hz.rr1_reg_D)) hz.forwardD = BFWD_WB;
  end

  // A load in EX cannot feed decode; a load in MEM cannot feed a decode-stage branch.
  assign ld_haz =
      (hz.mem_to_regX && (src_match(hz.reg_wr_enX, hz.write_regX, hz.rr1_reg_D) ||
                          src_match(hz.reg_wr_enX, hz.write_regX, hz.rr2_reg_D))) ||
      (hz.branch_D && hz.mem_to_regM &&
       src_match(hz.reg_wr_enM, hz.write_regM, hz.rr1_reg_D));

  mem_wait_fsm #(
    .TIMEOUT (TIMEOUT)
  ) u_mem_wait (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (hz.mem_req_M),
    .mem_ready   (hz.mem_ready),
    .mem_stall   (mem_stall),
    .mem_timeout (hz.mem_timeout)
  );

  always_comb begin
    hz.stall_F  = 1'b0;
    hz.stall_D  = 1'b0;
    hz.stall_X  = 1'b0;
    hz.stall_M  = 1'b0;
    hz.bubble_X = 1'b0;
    hz.bubble_W = 1'b0;
    hz.flush_D  = 1'b0;
    if (mem_stall) begin
      hz.stall_F  = 1'b1;
      hz.stall_D  = 1'b1;
      hz.stall_X  = 1'b1;
      hz.stall_M  = 1'b1;
      hz.bubble_W = 1'b1;
    end else if (ld_haz) begin
      // A taken branch waiting on load data is not flushed; it re-resolves next cycle.
      hz.stall_F  = 1'b1;
      hz.stall_D  = 1'b1;
      hz.bubble_X = 1'b1;
    end else if (hz.branch_taken_D) begin
      hz.flush_D = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                 stall_cnt_q <= '0;
    else if (hz.stall_F && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign hz.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_mc.sv
// Directed bench for hazard_forward_mc: a driver queues hand-computed expected
// outputs per cycle and a monitor compares them mid-cycle.
module tb_hazard_forward_mc;

  localparam int REG_W = 4;
  localparam int CNT_W = 4;

  // {stall_F, stall_D, stall_X, stall_M, bubble_X, bubble_W, flush_D}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LD   = 7'b1100100;
  localparam logic [6:0] C_MEM  = 7'b1111010;
  localparam logic [6:0] C_FL   = 7'b0000001;

  typedef struct {
    logic             rst;
    logic             we_x, we_m, we_w;
    logic [REG_W-1:0] wr_x, wr_m, wr_w;
    logic             m2r_x, m2r_m;
    logic [REG_W-1:0] rr1_d, rr2_d, rr1_x, rr2_x;
    logic             br, br_taken, req, ready;
  } vin_t;

  typedef struct {
    logic [1:0]       fa, fb, fd;
    logic [6:0]       ctl;
    logic             tmo;
    logic [CNT_W-1:0] sc;
  } vexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vexp_t exp_q[$];

  always #5 clk = ~clk;

  hazard_forward_mc_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();

  hazard_forward_mc #(
    .REG_W              (REG_W),
    .ZERO_REG_HARDWIRED (1),
    .TIMEOUT            (4),
    .CNT_W              (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic vin_t idle_in();
    vin_t v;
    v = '{rst: 1'b0, we_x: 1'b0, we_m: 1'b0, we_w: 1'b0,
          wr_x: '0, wr_m: '0, wr_w: '0, m2r_x: 1'b0, m2r_m: 1'b0,
          rr1_d: '0, rr2_d: '0, rr1_x: '0, rr2_x: '0,
          br: 1'b0, br_taken: 1'b0, req: 1'b0, ready: 1'b0};
    return v;
  endfunction

  function automatic vexp_t ex(input logic [1:0] fa, input logic [1:0] fb,
                               input logic [1:0] fd, input logic [6:0] ctl,
                               input logic tmo, input int sc);
    vexp_t e;
    e = '{fa: fa, fb: fb, fd: fd, ctl: ctl, tmo: tmo, sc: CNT_W'(sc)};
    return e;
  endfunction

  task automatic apply(input vin_t v);
    rst               = v.rst;
    hz.reg_wr_enX     = v.we_x;
    hz.reg_wr_enM     = v.we_m;
    hz.reg_wr_enW     = v.we_w;
    hz.write_regX     = v.wr_x;
    hz.write_regM     = v.wr_m;
    hz.write_regW     = v.wr_w;
    hz.mem_to_regX    = v.m2r_x;
    hz.mem_to_regM    = v.m2r_m;
    hz.rr1_reg_D      = v.rr1_d;
    hz.rr2_reg_D      = v.rr2_d;
    hz.rr1_reg_X      = v.rr1_x;
    hz.rr2_reg_X      = v.rr2_x;
    hz.branch_D       = v.br;
    hz.branch_taken_D = v.br_taken;
    hz.mem_req_M      = v.req;
    hz.mem_ready      = v.ready;
  endtask

  task automatic step(input vin_t v, input vexp_t e);
    @(posedge clk);
    #1;
    apply(v);
    exp_q.push_back(e);
  endtask

  // Monitor: compares whatever expectation is pending at each falling edge.
  initial begin
    vexp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("forward_A_selX", 32'(hz.forward_A_selX), 32'(e.fa));
        check("forward_B_selX", 32'(hz.forward_B_selX), 32'(e.fb));
        check("forwardD",       32'(hz.forwardD),       32'(e.fd));
        check("stall_bubble_flush",
              32'({hz.stall_F, hz.stall_D, hz.stall_X, hz.stall_M,
                   hz.bubble_X, hz.bubble_W, hz.flush_D}), 32'(e.ctl));
        check("mem_timeout",    32'(hz.mem_timeout),    32'(e.tmo));
        check("stall_cycles",   32'(hz.stall_cycles),   32'(e.sc));
      end
    end
  end

  initial begin
    vin_t v;
    apply(idle_in());
    rst = 1'b1;

    // Reset state
    v = idle_in(); v.rst = 1'b1;
    step(v, ex(2'b00, 2'b00, 2'b00, C_NONE, 1'b0, 0));
    step(v, ex(2'b00, 2'b00, 2'b00, C_NONE, 1'b0, 0));

    // MEM beats WB on both ALU operands; branch operand from MEM
    v = idle_in(); v.we_m = 1; v.we_w = 1; v.wr_m = 5; v.wr_w = 5;
    v.rr1_x = 5; v.rr2_x = 5; v.rr1_d = 5;
    step(v, ex(2'b01, 2'b01, 2'b10, C_NONE, 1'b0, 0));

    // Register 0 is never forwarded
    v.wr_m = 0; v.wr_w = 0; v.rr1_x = 0; v.rr2_x = 0; v.rr1_d = 0;
    step(v, ex(2'b00, 2'b00, 2'b00, C_NONE, 1'b0, 0));

    // WB-only source
    v = idle_in(); v.we_w = 1; v.wr_w = 9; v.rr1_x = 9; v.rr2_x = 4; v.rr1_d = 9;
    step(v, ex(2'b10, 2'b00, 2'b11, C_NONE, 1'b0, 0));

    // EX beats MEM for the branch operand
    v = idle_in(); v.we_x = 1; v.wr_x = 6; v.we_m = 1; v.wr_m = 6;
    v.rr1_d = 6; v.rr2_x = 6;
    step(v, ex(2'b00, 2'b01, 2'b01, C_NONE, 1'b0, 0));

    // Load-use: one stall cycle, then clear once the load is in MEM
    v = idle_in(); v.we_x = 1; v.m2r_x = 1; v.wr_x = 3; v.rr2_d = 3;
    step(v, ex(2'b00, 2'b00, 2'b00, C_LD, 1'b0, 0));
    v = idle_in(); v.we_m = 1; v.m2r_m = 1; v.wr_m = 3; v.rr2_d = 3;
    step(v, ex(2'b00, 2'b00, 2'b00, C_NONE, 1'b0, 1));

    // Taken branch behind a load in MEM: stall, no flush; then flush
    v = idle_in(); v.br = 1; v.br_taken = 1; v.we_m = 1; v.m2r_m = 1;
    v.wr_m = 7; v.rr1_d = 7;
    step(v, ex(2'b00, 2'b00, 2'b10, C_LD, 1'b0, 1));
    v.m2r_m = 0;
    step(v, ex(2'b00, 2'b00, 2'b10, C_FL, 1'b0, 2));

    // Memory wait of three cycles
    v = idle_in(); v.req = 1; v.ready = 0;
    for (int i = 0; i < 3; i++) step(v, ex(2'b00, 2'b00, 2'b00, C_MEM, 1'b0, 2 + i));
    v.ready = 1;
    step(v, ex(2'b00, 2'b00, 2'b00, C_NONE, 1'b0, 5));
    // Back in IDLE: ready in the request cycle adds no stall
    step(v, ex(2'b00, 2'b00, 2'b00, C_NONE, 1'b0, 5));

    // Memory stall outranks a simultaneous load-use hazard
    v = idle_in(); v.req = 1; v.ready = 0; v.we_x = 1; v.m2r_x = 1; v.wr_x = 3; v.rr2_d = 3;
    step(v, ex(2'b00, 2'b00, 2'b00, C_MEM, 1'b0, 5));
    v = idle_in(); v.req = 1; v.ready = 1;
    step(v, ex(2'b00, 2'b00, 2'b00, C_NONE, 1'b0, 6));

    // Timeout (TIMEOUT=4): four stall cycles, abort, sticky error
    v = idle_in(); v.req = 1; v.ready = 0;
    for (int i = 0; i < 4; i++) step(v, ex(2'b00, 2'b00, 2'b00, C_MEM, 1'b0, 6 + i));
    v = idle_in();
    step(v, ex(2'b00, 2'b00, 2'b00, C_NONE, 1'b0, 10));
    step(v, ex(2'b00, 2'b00, 2'b00, C_NONE, 1'b1, 10));
    step(v, ex(2'b00, 2'b00, 2'b00, C_NONE, 1'b1, 10));

    // Reset in the middle of MEM_WAIT
    v = idle_in(); v.req = 1; v.ready = 0;
    step(v, ex(2'b00, 2'b00, 2'b00, C_MEM, 1'b1, 10));
    v.req = 0;
    step(v, ex(2'b00, 2'b00, 2'b00, C_MEM, 1'b1, 11));
    v.rst = 1;
    step(v, ex(2'b00, 2'b00, 2'b00, C_MEM, 1'b1, 12));
    v = idle_in();
    step(v, ex(2'b00, 2'b00, 2'b00, C_NONE, 1'b0, 0));
    step(v, ex(2'b00, 2'b00, 2'b00, C_NONE, 1'b0, 0));

    // Counter saturates at all-ones (CNT_W=4 -> 15)
    v = idle_in(); v.we_x = 1; v.m2r_x = 1; v.wr_x = 3; v.rr2_d = 3;
    for (int i = 0; i < 18; i++)
      step(v, ex(2'b00, 2'b00, 2'b00, C_LD, 1'b0, (i > 15) ? 15 : i));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
